// File: rtl/hydra_strand_pkg.sv
// Shared strand definitions: default widths, WS2811 timing at 50 MHz,
// receiver state encoding and a 3-sample majority helper.
package hydra_strand_pkg;

   localparam int STRAND_MEM_DATA_WIDTH     = 24;
   localparam int STRAND_PARAM_WIDTH_DFLT   = 16;

   localparam int WS_BIT_THRESHOLD = 30;
   localparam int WS_HIGH_MAX      = 100;
   localparam int WS_RESET_CYCLES  = 2500;

   typedef enum logic [1:0] {
      RX_SYNC = 2'd0,
      RX_IDLE = 2'd1,
      RX_HIGH = 2'd2,
      RX_LOW  = 2'd3
   } rx_state_e;

   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/strand_din_conditioner.sv
// Brings the asynchronous strand line into the clk domain and produces a clean
// level plus rise/fall strobes; WS2811_RX_GLITCH_FILTER_EN adds a majority filter.
module strand_din_conditioner
   import hydra_strand_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic din_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic sync1_q;
   logic sync2_q;
   logic level_q;
   logic rise_q;
   logic fall_q;
   logic src_s;

`ifdef WS2811_RX_GLITCH_FILTER_EN
   logic [2:0] hist_q;

   // A level change only passes once two of the last three samples agree.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= 3'b000;
      end else begin
         hist_q <= {hist_q[1:0], sync2_q};
      end
   end

   assign src_s = maj3(hist_q);
`else
   assign src_s = sync2_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= din_i;
         sync2_q <= sync1_q;
         level_q <= src_s;
         rise_q  <= src_s & ~level_q;
         fall_q  <= ~src_s & level_q;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/ws2811_receiver.sv
// WS2811 NRZ stream decoder: pulse-width bit decode, 24-bit pixel assembly, latch-gap framing.
// Build option WS2811_RX_GLITCH_FILTER_EN enables the din majority filter (+2 cycles latency).
module ws2811_receiver
   import hydra_strand_pkg::*;
#(
   parameter int MEM_DATA_WIDTH     = STRAND_MEM_DATA_WIDTH,
   parameter int STRAND_PARAM_WIDTH = STRAND_PARAM_WIDTH_DFLT,
   parameter int BIT_THRESHOLD      = WS_BIT_THRESHOLD,
   parameter int HIGH_MAX           = WS_HIGH_MAX,
   parameter int RESET_CYCLES       = WS_RESET_CYCLES
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          din,
   output logic [MEM_DATA_WIDTH-1:0]     pixel_data,
   output logic                          pixel_valid,
   output logic [STRAND_PARAM_WIDTH-1:0] pixel_idx,
   output logic                          frame_done,
   output logic [STRAND_PARAM_WIDTH-1:0] frame_length,
   output logic                          busy,
   output logic                          error
);

   localparam int CNT_MAX = (RESET_CYCLES > HIGH_MAX) ? RESET_CYCLES : HIGH_MAX;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BCNT_W  = $clog2(MEM_DATA_WIDTH);

   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  BIT_LIM  = CNT_W'(BIT_THRESHOLD);
   localparam logic [CNT_W-1:0]  HIGH_LIM = CNT_W'(HIGH_MAX - 1);
   localparam logic [CNT_W-1:0]  GAP_LIM  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(MEM_DATA_WIDTH - 1);
   localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1);
   localparam logic [STRAND_PARAM_WIDTH-1:0] IDX_ONE = STRAND_PARAM_WIDTH'(1);

   logic level_s;
   logic rise_s;
   logic fall_s;

   strand_din_conditioner u_cond (
      .clk     (clk),
      .rst     (rst),
      .din_i   (din),
      .level_o (level_s),
      .rise_o  (rise_s),
      .fall_o  (fall_s)
   );

   rx_state_e                     state_q;
   logic [CNT_W-1:0]              cnt_q;
   logic [BCNT_W-1:0]             bit_cnt_q;
   logic [MEM_DATA_WIDTH-2:0]     shift_q;
   logic [STRAND_PARAM_WIDTH-1:0] pix_cnt_q;
   logic [MEM_DATA_WIDTH-1:0]     pixel_data_q;
   logic                          pixel_valid_q;
   logic [STRAND_PARAM_WIDTH-1:0] pixel_idx_q;
   logic                          frame_done_q;
   logic [STRAND_PARAM_WIDTH-1:0] frame_length_q;
   logic                          busy_q;
   logic                          error_q;

   logic [CNT_W-1:0]              cnt_d;
   logic                          bit_d;
   logic [MEM_DATA_WIDTH-1:0]     shift_d;
   logic [STRAND_PARAM_WIDTH-1:0] pix_cnt_d;

   // Counters saturate; the pulse measured at the fall edge equals its width in cycles.
   assign cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;
   assign bit_d     = (cnt_q >= BIT_LIM);
   assign shift_d   = {shift_q, bit_d};
   assign pix_cnt_d = (pix_cnt_q == {STRAND_PARAM_WIDTH{1'b1}}) ? pix_cnt_q : pix_cnt_q + IDX_ONE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= RX_SYNC;
         cnt_q          <= '0;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         pix_cnt_q      <= '0;
         pixel_data_q   <= '0;
         pixel_valid_q  <= 1'b0;
         pixel_idx_q    <= '0;
         frame_done_q   <= 1'b0;
         frame_length_q <= '0;
         busy_q         <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         pixel_valid_q <= 1'b0;
         frame_done_q  <= 1'b0;
         error_q       <= 1'b0;
         case (state_q)
            RX_SYNC: begin
               if (level_s) begin
                  cnt_q <= '0;
               end else if (cnt_q >= GAP_LIM) begin
                  cnt_q   <= '0;
                  state_q <= RX_IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            RX_IDLE: begin
               bit_cnt_q <= '0;
               pix_cnt_q <= '0;
               // The rise sample itself is the first high cycle of the pulse.
               if (rise_s) begin
                  cnt_q   <= CNT_ONE;
                  busy_q  <= 1'b1;
                  state_q <= RX_HIGH;
               end else begin
                  cnt_q <= '0;
               end
            end
            RX_HIGH: begin
               if (fall_s) begin
                  cnt_q   <= CNT_ONE;
                  state_q <= RX_LOW;
                  if (bit_cnt_q == LAST_BIT) begin
                     pixel_data_q  <= shift_d;
                     pixel_valid_q <= 1'b1;
                     pixel_idx_q   <= pix_cnt_q;
                     pix_cnt_q     <= pix_cnt_d;
                     bit_cnt_q     <= '0;
                     shift_q       <= '0;
                  end else begin
                     shift_q   <= shift_d[MEM_DATA_WIDTH-2:0];
                     bit_cnt_q <= bit_cnt_q + BCNT_ONE;
                  end
               end else if (cnt_q >= HIGH_LIM) begin
                  error_q   <= 1'b1;
                  busy_q    <= 1'b0;
                  cnt_q     <= '0;
                  bit_cnt_q <= '0;
                  shift_q   <= '0;
                  pix_cnt_q <= '0;
                  state_q   <= RX_SYNC;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            RX_LOW: begin
               if (rise_s) begin
                  cnt_q   <= CNT_ONE;
                  state_q <= RX_HIGH;
               end else if (cnt_q >= GAP_LIM) begin
                  frame_done_q   <= 1'b1;
                  frame_length_q <= pix_cnt_q;
                  error_q        <= (bit_cnt_q != '0);
                  busy_q         <= 1'b0;
                  cnt_q          <= '0;
                  bit_cnt_q      <= '0;
                  shift_q        <= '0;
                  pix_cnt_q      <= '0;
                  state_q        <= RX_IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               cnt_q     <= '0;
               bit_cnt_q <= '0;
               shift_q   <= '0;
               pix_cnt_q <= '0;
               busy_q    <= 1'b0;
               state_q   <= RX_SYNC;
            end
         endcase
      end
   end

   assign pixel_data   = pixel_data_q;
   assign pixel_valid  = pixel_valid_q;
   assign pixel_idx    = pixel_idx_q;
   assign frame_done   = frame_done_q;
   assign frame_length = frame_length_q;
   assign busy         = busy_q;
   assign error        = error_q;

endmodule
